id_ex_operand_stage: RTL and testbench
======================================

Name: id_ex_operand_stage

Overview:
ID/EX pipeline register that sits directly upstream of the EX-stage ALU and drives its operand and opcode inputs. It latches decoded fields from ID, handles stall and flush, forwards results from EX/MEM and MEM/WB, and selects ALU operands. It also flags load-use hazards to the hazard unit.

Parameters:
NB_DATA, 32, datapath width
N_BITS_CONTROL, 5, ALU opcode width
NB_REG_ADDR, 5, register-file address width
NB_SHAMT, 5, shift-amount field width

Ports:
i_clock  in  1  rising-edge clock
i_reset_n  in  1  asynchronous, active-low reset
i_valid  in  1  ID holds a real instruction
i_rs_data / i_rt_data  in  NB_DATA  register-file read data
i_imm_ext  in  NB_DATA  sign/zero-extended immediate from ID
i_shamt  in  NB_SHAMT  instruction shamt field
i_rs_addr / i_rt_addr / i_rd_addr  in  NB_REG_ADDR  source and destination register numbers
i_alu_opcode  in  N_BITS_CONTROL  ALU operation
i_alu_src_imm  in  1  operand B = immediate
i_shift_src_shamt  in  1  fixed shift: A = rt, B = shamt
i_write_to_rt  in  1  destination = rt, else rd
i_reg_write / i_mem_read / i_mem_write  in  1  control bits
i_stall  in  1  hold stage contents
i_flush  in  1  load a bubble
i_exmem_reg_write, i_exmem_rd_addr, i_exmem_data  in  1/NB_REG_ADDR/NB_DATA  EX/MEM forwarding source
i_memwb_reg_write, i_memwb_rd_addr, i_memwb_data  in  1/NB_REG_ADDR/NB_DATA  MEM/WB forwarding source
o_data_a / o_data_b  out  NB_DATA  ALU operands
o_alu_opcode  out  N_BITS_CONTROL  to the ALU opcode input
o_store_data  out  NB_DATA  forwarded rt value, used by stores
o_dest_addr  out  NB_REG_ADDR  resolved destination register
o_reg_write / o_mem_read / o_mem_write / o_valid  out  1  registered control bits, all 0 in a bubble
o_load_use_hazard  out  1  combinational stall request to the hazard unit

Behaviour:
- Reset (async, i_reset_n=0): all registered fields are 0, so every output is 0, including opcode 00000 and o_load_use_hazard.
- Register update on each rising edge, priority high to low:
  - i_stall=1: hold all fields. A flush asserted in the same cycle is ignored; upstream must keep i_flush high until i_stall drops.
  - i_flush=1: load a bubble. Valid, reg_write, mem_read and mem_write are 0; all other fields are 0.
  - Otherwise: capture all inputs. Control bits are ANDed with i_valid.
- Destination is resolved at capture: dest = i_write_to_rt ? i_rt_addr : i_rd_addr.
- Latency: one cycle from ID to the outputs.
- Forwarding is combinational on the registered rs/rt numbers and applies every cycle, including stalled cycles.
  - For register number r: if r≠0, i_exmem_reg_write=1 and i_exmem_rd_addr==r, use i_exmem_data.
  - Else if r≠0, i_memwb_reg_write=1 and i_memwb_rd_addr==r, use i_memwb_data.
  - Else use the registered read data.
  - EX/MEM has priority over MEM/WB. r=0 is never forwarded.
- Operand select:
  - Shift_src_shamt=1: o_data_a = fwd_rt, o_data_b = zero-extended shamt.
  - Otherwise: o_data_a = fwd_rs, o_data_b = alu_src_imm ? imm : fwd_rt.
  - o_store_data = fwd_rt always.
- o_load_use_hazard = o_valid & o_mem_read & (dest≠0) & i_valid & (dest==i_rs_addr | dest==i_rt_addr). It depends only on the current register contents and ID inputs.
- Reset mid-operation clears the stage immediately, with no wait for a clock edge.

Test Plan:
- Reset then capture: with i_reset_n=0, all outputs are 0. Release reset; ID presents rs=3 (data 5), rt=4 (data 7), opcode 00010, no imm, valid. After one edge: o_data_a=5, o_data_b=7, o_alu_opcode=00010, o_valid=1.
- Forward priority: registered rs=8. EX/MEM (write, addr 8, 0xAAAA) and MEM/WB (write, addr 8, 0xBBBB) are both active → o_data_a=0xAAAA. Drop EX/MEM write → 0xBBBB. With rs=0 and both sources targeting addr 0 → the raw value is kept.
- Shift select: i_shift_src_shamt=1, rt data 0x1, shamt 4, opcode 00110 → o_data_a=0x1, o_data_b=0x4. Immediate path: i_alu_src_imm=1, imm 0xFFFFFFF0 → o_data_b=0xFFFFFFF0.
- Stall/flush: stall for 3 cycles while ID inputs change → outputs stay constant. Assert stall and flush together → contents are held. Flush alone → o_valid, o_reg_write, o_mem_read and o_mem_write are 0, and o_alu_opcode=00000.
- Load-use: registered lw with dest rt=9 (i_write_to_rt=1, mem_read=1). ID shows rs=9, valid → o_load_use_hazard=1. ID rs=9 but i_valid=0 → 0. dest=0 → 0.
- Async reset mid-stall: assert i_reset_n=0 between clock edges → outputs go to 0 before the next edge.

Source files
------------

// File: rtl/id_ex_operand_stage_if.sv
// ID/EX operand stage bus: ID fields, forwarding sources and ALU-side outputs.
// The master drives ID and forwarding inputs; the slave is the stage itself.
interface id_ex_operand_stage_if #(
  parameter int NB_DATA        = 32,
  parameter int N_BITS_CONTROL = 5,
  parameter int NB_REG_ADDR    = 5,
  parameter int NB_SHAMT       = 5
);
  logic                      i_valid;
  logic [NB_DATA-1:0]        i_rs_data;
  logic [NB_DATA-1:0]        i_rt_data;
  logic [NB_DATA-1:0]        i_imm_ext;
  logic [NB_SHAMT-1:0]       i_shamt;
  logic [NB_REG_ADDR-1:0]    i_rs_addr;
  logic [NB_REG_ADDR-1:0]    i_rt_addr;
  logic [NB_REG_ADDR-1:0]    i_rd_addr;
  logic [N_BITS_CONTROL-1:0] i_alu_opcode;
  logic                      i_alu_src_imm;
  logic                      i_shift_src_shamt;
  logic                      i_write_to_rt;
  logic                      i_reg_write;
  logic                      i_mem_read;
  logic                      i_mem_write;
  logic                      i_stall;
  logic                      i_flush;
  logic                      i_exmem_reg_write;
  logic [NB_REG_ADDR-1:0]    i_exmem_rd_addr;
  logic [NB_DATA-1:0]        i_exmem_data;
  logic                      i_memwb_reg_write;
  logic [NB_REG_ADDR-1:0]    i_memwb_rd_addr;
  logic [NB_DATA-1:0]        i_memwb_data;

  logic [NB_DATA-1:0]        o_data_a;
  logic [NB_DATA-1:0]        o_data_b;
  logic [N_BITS_CONTROL-1:0] o_alu_opcode;
  logic [NB_DATA-1:0]        o_store_data;
  logic [NB_REG_ADDR-1:0]    o_dest_addr;
  logic                      o_reg_write;
  logic                      o_mem_read;
  logic                      o_mem_write;
  logic                      o_valid;
  logic                      o_load_use_hazard;

  modport master (
    output i_valid, i_rs_data, i_rt_data, i_imm_ext, i_shamt,
    output i_rs_addr, i_rt_addr, i_rd_addr, i_alu_opcode,
    output i_alu_src_imm, i_shift_src_shamt, i_write_to_rt,
    output i_reg_write, i_mem_read, i_mem_write,
    output i_stall, i_flush,
    output i_exmem_reg_write, i_exmem_rd_addr, i_exmem_data,
    output i_memwb_reg_write, i_memwb_rd_addr, i_memwb_data,
    input  o_data_a, o_data_b, o_alu_opcode, o_store_data,
    input  o_dest_addr, o_reg_write, o_mem_read, o_mem_write,
    input  o_valid, o_load_use_hazard
  );

  modport slave (
    input  i_valid, i_rs_data, i_rt_data, i_imm_ext, i_shamt,
    input  i_rs_addr, i_rt_addr, i_rd_addr, i_alu_opcode,
    input  i_alu_src_imm, i_shift_src_shamt, i_write_to_rt,
    input  i_reg_write, i_mem_read, i_mem_write,
    input  i_stall, i_flush,
    input  i_exmem_reg_write, i_exmem_rd_addr, i_exmem_data,
    input  i_memwb_reg_write, i_memwb_rd_addr, i_memwb_data,
    output o_data_a, o_data_b, o_alu_opcode, o_store_data,
    output o_dest_addr, o_reg_write, o_mem_read, o_mem_write,
    output o_valid, o_load_use_hazard
  );
endinterface

// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register feeding the ALU: stall/flush, operand forwarding,
// operand select and load-use hazard detection.
module id_ex_operand_stage #(
  parameter int NB_DATA        = 32,
  parameter int N_BITS_CONTROL = 5,
  parameter int NB_REG_ADDR    = 5,
  parameter int NB_SHAMT       = 5
) (
  input logic                  i_clock,
  input logic                  i_reset_n,
  id_ex_operand_stage_if.slave bus
);

  typedef struct packed {
    logic                      valid;
    logic                      reg_write;
    logic                      mem_read;
    logic                      mem_write;
    logic                      alu_src_imm;
    logic                      shift_src_shamt;
    logic [N_BITS_CONTROL-1:0] opcode;
    logic [NB_REG_ADDR-1:0]    rs_addr;
    logic [NB_REG_ADDR-1:0]    rt_addr;
    logic [NB_REG_ADDR-1:0]    dest;
    logic [NB_SHAMT-1:0]       shamt;
    logic [NB_DATA-1:0]        rs_data;
    logic [NB_DATA-1:0]        rt_data;
    logic [NB_DATA-1:0]        imm;
  } id_ex_t;

  id_ex_t id_ex_d;
  id_ex_t id_ex_q;

  logic [NB_DATA-1:0] fwd_rs;
  logic [NB_DATA-1:0] fwd_rt;
  logic [NB_DATA-1:0] shamt_ext;
  logic               dest_hit;

  // Stall outranks flush so a held instruction is never dropped
  always_comb begin
    id_ex_d = id_ex_q;
    if (bus.i_stall) begin
      id_ex_d = id_ex_q;
    end else if (bus.i_flush) begin
      id_ex_d = '0;
    end else begin
      id_ex_d.valid           = bus.i_valid;
      id_ex_d.reg_write       = bus.i_reg_write & bus.i_valid;
      id_ex_d.mem_read        = bus.i_mem_read & bus.i_valid;
      id_ex_d.mem_write       = bus.i_mem_write & bus.i_valid;
      id_ex_d.alu_src_imm     = bus.i_alu_src_imm;
      id_ex_d.shift_src_shamt = bus.i_shift_src_shamt;
      id_ex_d.opcode          = bus.i_alu_opcode;
      id_ex_d.rs_addr         = bus.i_rs_addr;
      id_ex_d.rt_addr         = bus.i_rt_addr;
      id_ex_d.dest            = bus.i_write_to_rt ? bus.i_rt_addr
                                                  : bus.i_rd_addr;
      id_ex_d.shamt           = bus.i_shamt;
      id_ex_d.rs_data         = bus.i_rs_data;
      id_ex_d.rt_data         = bus.i_rt_data;
      id_ex_d.imm             = bus.i_imm_ext;
    end
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      id_ex_q <= '0;
    end else begin
      id_ex_q <= id_ex_d;
    end
  end

  function automatic logic [NB_DATA-1:0] fwd_sel(
    input logic [NB_REG_ADDR-1:0] r,
    input logic [NB_DATA-1:0]     raw,
    input logic                   ex_we,
    input logic [NB_REG_ADDR-1:0] ex_rd,
    input logic [NB_DATA-1:0]     ex_data,
    input logic                   wb_we,
    input logic [NB_REG_ADDR-1:0] wb_rd,
    input logic [NB_DATA-1:0]     wb_data
  );
    logic nz;
    nz = |r;
    if (nz && ex_we && (ex_rd == r)) begin
      return ex_data;
    end else if (nz && wb_we && (wb_rd == r)) begin
      return wb_data;
    end
    return raw;
  endfunction

  // The newer EX/MEM result wins over MEM/WB; r0 is hardwired zero
  always_comb begin
    fwd_rs = fwd_sel(id_ex_q.rs_addr, id_ex_q.rs_data,
                     bus.i_exmem_reg_write, bus.i_exmem_rd_addr,
                     bus.i_exmem_data,
                     bus.i_memwb_reg_write, bus.i_memwb_rd_addr,
                     bus.i_memwb_data);
    fwd_rt = fwd_sel(id_ex_q.rt_addr, id_ex_q.rt_data,
                     bus.i_exmem_reg_write, bus.i_exmem_rd_addr,
                     bus.i_exmem_data,
                     bus.i_memwb_reg_write, bus.i_memwb_rd_addr,
                     bus.i_memwb_data);
  end

  assign shamt_ext = {{(NB_DATA-NB_SHAMT){1'b0}}, id_ex_q.shamt};

  always_comb begin
    bus.o_data_a = fwd_rs;
    bus.o_data_b = id_ex_q.alu_src_imm ? id_ex_q.imm : fwd_rt;
    if (id_ex_q.shift_src_shamt) begin
      bus.o_data_a = fwd_rt;
      bus.o_data_b = shamt_ext;
    end
  end

  assign bus.o_store_data = fwd_rt;
  assign bus.o_alu_opcode = id_ex_q.opcode;
  assign bus.o_dest_addr  = id_ex_q.dest;
  assign bus.o_reg_write  = id_ex_q.reg_write;
  assign bus.o_mem_read   = id_ex_q.mem_read;
  assign bus.o_mem_write  = id_ex_q.mem_write;
  assign bus.o_valid      = id_ex_q.valid;

  assign dest_hit = (id_ex_q.dest == bus.i_rs_addr) |
                    (id_ex_q.dest == bus.i_rt_addr);

  assign bus.o_load_use_hazard = id_ex_q.valid & id_ex_q.mem_read &
                                 (|id_ex_q.dest) & bus.i_valid &
                                 dest_hit;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Randomized self-checking bench for id_ex_operand_stage against
// a behavioural model of the stage register and forwarding rules.
module tb_id_ex_operand_stage;

  localparam int NBD = 32;
  localparam int NBC = 5;
  localparam int NBA = 5;
  localparam int NBS = 5;
  localparam int OW  = 3*NBD + NBC + NBA + 5;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;

  id_ex_operand_stage_if #(
    .NB_DATA(NBD), .N_BITS_CONTROL(NBC),
    .NB_REG_ADDR(NBA), .NB_SHAMT(NBS)
  ) bus ();

  id_ex_operand_stage #(
    .NB_DATA(NBD), .N_BITS_CONTROL(NBC),
    .NB_REG_ADDR(NBA), .NB_SHAMT(NBS)
  ) dut (
    .i_clock  (clk),
    .i_reset_n(rst_n),
    .bus      (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model of the stage contents (what was accepted from ID)
  logic           m_valid, m_rw, m_mr, m_mw, m_imm_sel, m_shift;
  logic [NBC-1:0] m_op;
  logic [NBA-1:0] m_rs, m_rt, m_dest;
  logic [NBS-1:0] m_shamt;
  logic [NBD-1:0] m_rs_d, m_rt_d, m_imm;

  task automatic mdl_clear();
    m_valid = 0; m_rw = 0; m_mr = 0; m_mw = 0;
    m_imm_sel = 0; m_shift = 0; m_op = '0;
    m_rs = '0; m_rt = '0; m_dest = '0; m_shamt = '0;
    m_rs_d = '0; m_rt_d = '0; m_imm = '0;
  endtask

  task automatic mdl_clock();
    if (!rst_n || bus.i_stall) return;
    if (bus.i_flush) begin
      mdl_clear();
      return;
    end
    m_valid   = bus.i_valid;
    m_rw      = bus.i_reg_write && bus.i_valid;
    m_mr      = bus.i_mem_read && bus.i_valid;
    m_mw      = bus.i_mem_write && bus.i_valid;
    m_imm_sel = bus.i_alu_src_imm;
    m_shift   = bus.i_shift_src_shamt;
    m_op      = bus.i_alu_opcode;
    m_rs      = bus.i_rs_addr;
    m_rt      = bus.i_rt_addr;
    m_dest    = bus.i_write_to_rt ? bus.i_rt_addr : bus.i_rd_addr;
    m_shamt   = bus.i_shamt;
    m_rs_d    = bus.i_rs_data;
    m_rt_d    = bus.i_rt_data;
    m_imm     = bus.i_imm_ext;
  endtask

  function automatic logic [NBD-1:0] m_fwd(input logic [NBA-1:0] r,
                                           input logic [NBD-1:0] raw);
    if (r == 0) return raw;
    if (bus.i_exmem_reg_write && bus.i_exmem_rd_addr == r)
      return bus.i_exmem_data;
    if (bus.i_memwb_reg_write && bus.i_memwb_rd_addr == r)
      return bus.i_memwb_data;
    return raw;
  endfunction

  function automatic logic [OW-1:0] exp_outs();
    logic [NBD-1:0] a, b, st;
    logic hz;
    st = m_fwd(m_rt, m_rt_d);
    if (m_shift) begin
      a = st;
      b = NBD'(m_shamt);
    end else begin
      a = m_fwd(m_rs, m_rs_d);
      b = m_imm_sel ? m_imm : st;
    end
    hz = m_valid && m_mr && m_dest != 0 && bus.i_valid &&
         (m_dest == bus.i_rs_addr || m_dest == bus.i_rt_addr);
    return {a, b, m_op, st, m_dest, m_rw, m_mr, m_mw, m_valid, hz};
  endfunction

  function automatic logic [OW-1:0] dut_outs();
    return {bus.o_data_a, bus.o_data_b, bus.o_alu_opcode,
            bus.o_store_data, bus.o_dest_addr, bus.o_reg_write,
            bus.o_mem_read, bus.o_mem_write, bus.o_valid,
            bus.o_load_use_hazard};
  endfunction

  task automatic tick();
    @(posedge clk);
    mdl_clock();
    @(negedge clk);
  endtask

  task automatic clr_in();
    bus.i_valid = 0; bus.i_rs_data = '0; bus.i_rt_data = '0;
    bus.i_imm_ext = '0; bus.i_shamt = '0; bus.i_rs_addr = '0;
    bus.i_rt_addr = '0; bus.i_rd_addr = '0; bus.i_alu_opcode = '0;
    bus.i_alu_src_imm = 0; bus.i_shift_src_shamt = 0;
    bus.i_write_to_rt = 0; bus.i_reg_write = 0; bus.i_mem_read = 0;
    bus.i_mem_write = 0; bus.i_stall = 0; bus.i_flush = 0;
    bus.i_exmem_reg_write = 0; bus.i_exmem_rd_addr = '0;
    bus.i_exmem_data = '0; bus.i_memwb_reg_write = 0;
    bus.i_memwb_rd_addr = '0; bus.i_memwb_data = '0;
  endtask

  task automatic rand_in();
    bus.i_valid = 1'($urandom);
    bus.i_rs_data = $urandom; bus.i_rt_data = $urandom;
    bus.i_imm_ext = $urandom; bus.i_shamt = NBS'($urandom);
    bus.i_rs_addr = NBA'($urandom_range(0, 4));
    bus.i_rt_addr = NBA'($urandom_range(0, 4));
    bus.i_rd_addr = NBA'($urandom_range(0, 4));
    bus.i_alu_opcode = NBC'($urandom);
    bus.i_alu_src_imm = 1'($urandom);
    bus.i_shift_src_shamt = 1'($urandom);
    bus.i_write_to_rt = 1'($urandom);
    bus.i_reg_write = 1'($urandom);
    bus.i_mem_read = 1'($urandom);
    bus.i_mem_write = 1'($urandom);
    bus.i_exmem_reg_write = 1'($urandom);
    bus.i_exmem_rd_addr = NBA'($urandom_range(0, 4));
    bus.i_exmem_data = $urandom;
    bus.i_memwb_reg_write = 1'($urandom);
    bus.i_memwb_rd_addr = NBA'($urandom_range(0, 4));
    bus.i_memwb_data = $urandom;
  endtask

  task automatic test_reset();
    rst_n = 0;
    mdl_clear();
    rand_in();
    #1;
    n_tests++;
    if (dut_outs() !== '0) begin
      n_fail++;
      $display("FAIL reset_outs got %h want 0", dut_outs());
    end
    tick();
    n_tests++;
    if (dut_outs() !== '0) begin
      n_fail++;
      $display("FAIL reset_held got %h want 0", dut_outs());
    end
    clr_in();
    rst_n = 1;
  endtask

  task automatic test_capture();
    clr_in();
    bus.i_rs_addr = 3; bus.i_rs_data = 5;
    bus.i_rt_addr = 4; bus.i_rt_data = 7;
    bus.i_alu_opcode = 5'b00010; bus.i_valid = 1;
    tick();
    n_tests++;
    if ({bus.o_data_a, bus.o_data_b, bus.o_alu_opcode, bus.o_valid} !==
        {32'd5, 32'd7, 5'b00010, 1'b1}) begin
      n_fail++;
      $display("FAIL capture got a=%h b=%h op=%b v=%b want 5 7 00010 1",
               bus.o_data_a, bus.o_data_b, bus.o_alu_opcode, bus.o_valid);
    end
    n_tests++;
    if (dut_outs() !== exp_outs()) begin
      n_fail++;
      $display("FAIL capture_model got %h want %h", dut_outs(), exp_outs());
    end
  endtask

  task automatic test_forward();
    clr_in();
    bus.i_rs_addr = 8; bus.i_rs_data = 32'h1111; bus.i_valid = 1;
    tick();
    bus.i_exmem_reg_write = 1; bus.i_exmem_rd_addr = 8;
    bus.i_exmem_data = 32'hAAAA;
    bus.i_memwb_reg_write = 1; bus.i_memwb_rd_addr = 8;
    bus.i_memwb_data = 32'hBBBB;
    #1;
    n_tests++;
    if (bus.o_data_a !== 32'hAAAA) begin
      n_fail++;
      $display("FAIL fwd_exmem got %h want 0000aaaa", bus.o_data_a);
    end
    bus.i_exmem_reg_write = 0;
    #1;
    n_tests++;
    if (bus.o_data_a !== 32'hBBBB) begin
      n_fail++;
      $display("FAIL fwd_memwb got %h want 0000bbbb", bus.o_data_a);
    end
    bus.i_memwb_reg_write = 0;
    #1;
    n_tests++;
    if (bus.o_data_a !== 32'h1111) begin
      n_fail++;
      $display("FAIL fwd_none got %h want 00001111", bus.o_data_a);
    end
    @(negedge clk);
    clr_in();
    bus.i_rs_addr = 0; bus.i_rs_data = 32'h1234; bus.i_valid = 1;
    bus.i_exmem_reg_write = 1; bus.i_exmem_data = 32'hAAAA;
    bus.i_memwb_reg_write = 1; bus.i_memwb_data = 32'hBBBB;
    tick();
    n_tests++;
    if (bus.o_data_a !== 32'h1234) begin
      n_fail++;
      $display("FAIL fwd_r0 got %h want 00001234", bus.o_data_a);
    end
  endtask

  task automatic test_operand_select();
    clr_in();
    bus.i_shift_src_shamt = 1; bus.i_rt_addr = 2; bus.i_rt_data = 1;
    bus.i_rs_addr = 1; bus.i_rs_data = 32'hDEAD;
    bus.i_shamt = 4; bus.i_alu_opcode = 5'b00110; bus.i_valid = 1;
    tick();
    n_tests++;
    if ({bus.o_data_a, bus.o_data_b, bus.o_alu_opcode} !==
        {32'h1, 32'h4, 5'b00110}) begin
      n_fail++;
      $display("FAIL shift_sel got a=%h b=%h op=%b want 1 4 00110",
               bus.o_data_a, bus.o_data_b, bus.o_alu_opcode);
    end
    clr_in();
    bus.i_alu_src_imm = 1; bus.i_imm_ext = 32'hFFFFFFF0;
    bus.i_rs_addr = 1; bus.i_rs_data = 32'h10;
    bus.i_rt_addr = 2; bus.i_rt_data = 32'h99; bus.i_valid = 1;
    tick();
    n_tests++;
    if ({bus.o_data_a, bus.o_data_b, bus.o_store_data} !==
        {32'h10, 32'hFFFFFFF0, 32'h99}) begin
      n_fail++;
      $display("FAIL imm_sel got a=%h b=%h st=%h want 10 fffffff0 99",
               bus.o_data_a, bus.o_data_b, bus.o_store_data);
    end
  endtask

  task automatic test_stall_flush();
    logic [OW-1:0] snap;
    clr_in();
    bus.i_rs_addr = 5; bus.i_rs_data = 32'h55; bus.i_rt_addr = 6;
    bus.i_rt_data = 32'h66; bus.i_alu_opcode = 5'b01001; bus.i_valid = 1;
    bus.i_reg_write = 1; bus.i_mem_write = 1;
    tick();
    snap = dut_outs();
    for (int i = 0; i < 3; i++) begin
      rand_in();
      bus.i_stall = 1; bus.i_flush = 0;
      bus.i_exmem_reg_write = 0; bus.i_memwb_reg_write = 0;
      bus.i_valid = 0;
      tick();
      n_tests++;
      if (dut_outs() !== snap) begin
        n_fail++;
        $display("FAIL stall_hold%0d got %h want %h", i, dut_outs(), snap);
      end
    end
    bus.i_stall = 1; bus.i_flush = 1;
    tick();
    n_tests++;
    if (dut_outs() !== snap) begin
      n_fail++;
      $display("FAIL stall_flush got %h want %h", dut_outs(), snap);
    end
    bus.i_stall = 0; bus.i_flush = 1;
    tick();
    n_tests++;
    if ({bus.o_valid, bus.o_reg_write, bus.o_mem_read, bus.o_mem_write,
         bus.o_alu_opcode} !== '0) begin
      n_fail++;
      $display("FAIL flush got v=%b rw=%b mr=%b mw=%b op=%b want zeros",
               bus.o_valid, bus.o_reg_write, bus.o_mem_read,
               bus.o_mem_write, bus.o_alu_opcode);
    end
    clr_in();
  endtask

  task automatic test_load_use();
    clr_in();
    bus.i_write_to_rt = 1; bus.i_rt_addr = 9; bus.i_rd_addr = 3;
    bus.i_mem_read = 1; bus.i_reg_write = 1; bus.i_valid = 1;
    tick();
    clr_in();
    bus.i_rs_addr = 9; bus.i_rt_addr = 2; bus.i_valid = 1;
    #1;
    n_tests++;
    if (bus.o_load_use_hazard !== 1'b1) begin
      n_fail++;
      $display("FAIL lu_hit got %b want 1", bus.o_load_use_hazard);
    end
    bus.i_valid = 0;
    #1;
    n_tests++;
    if (bus.o_load_use_hazard !== 1'b0) begin
      n_fail++;
      $display("FAIL lu_invalid got %b want 0", bus.o_load_use_hazard);
    end
    @(negedge clk);
    clr_in();
    bus.i_write_to_rt = 1; bus.i_rt_addr = 0;
    bus.i_mem_read = 1; bus.i_valid = 1;
    tick();
    clr_in();
    bus.i_valid = 1;
    #1;
    n_tests++;
    if (bus.o_load_use_hazard !== 1'b0) begin
      n_fail++;
      $display("FAIL lu_dest0 got %b want 0", bus.o_load_use_hazard);
    end
    @(negedge clk);
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      rand_in();
      bus.i_stall = ($urandom_range(0, 9) == 0);
      bus.i_flush = ($urandom_range(0, 9) == 0);
      tick();
      n_tests++;
      if (dut_outs() !== exp_outs()) begin
        n_fail++;
        $display("FAIL rand%0d got %h want %h", i, dut_outs(), exp_outs());
      end
    end
    clr_in();
  endtask

  task automatic test_async_reset();
    clr_in();
    bus.i_rs_addr = 7; bus.i_rs_data = 32'h77; bus.i_valid = 1;
    bus.i_reg_write = 1; bus.i_alu_opcode = 5'b00011;
    tick();
    bus.i_stall = 1;
    #2;
    rst_n = 0;
    mdl_clear();
    #1;
    n_tests++;
    if (dut_outs() !== '0) begin
      n_fail++;
      $display("FAIL async_reset got %h want 0", dut_outs());
    end
    @(negedge clk);
    rst_n = 1;
    clr_in();
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst_n   = 0;
    clr_in();
    mdl_clear();
    @(negedge clk);
    test_reset();
    test_capture();
    test_forward();
    test_operand_select();
    test_stall_flush();
    test_load_use();
    test_random();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
